cbus_mem_responder: RTL and testbench

- Responder (slave) end of the CBus: accepts the single `creq` stream that the cache/uncache arbiter drives, and answers with `ready`/`last`/`data` beats from an internal word-addressed RAM.
- Used as the memory model behind the cache subsystem in simulation, and as a synthesizable on-chip scratch memory.
- Supports single and burst (`len` + 1 beats) reads and writes, with a programmable first-beat latency.

---
 rtl/cbus_mem_responder_pkg.sv | 40 ++++
 rtl/cbus_mem_array.sv | 31 +++
 rtl/cbus_mem_responder.sv | 130 +++++++++++++
 tb/tb_cbus_mem_responder.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/cbus_mem_responder_pkg.sv
// Shared CBus definitions for the memory responder: request/response structs,
// len/size encodings, the responder FSM states and the bus word width.
package cbus_mem_responder_pkg;

  localparam int CBUS_WORD_BYTES = 4;

  typedef logic [3:0] cbus_len_t;
  localparam cbus_len_t CBUS_LEN_SINGLE = 4'd0;
  localparam cbus_len_t CBUS_LEN_16     = 4'd15;

  typedef enum logic [2:0] {
    CBUS_SIZE_BYTE = 3'd0,
    CBUS_SIZE_HALF = 3'd1,
    CBUS_SIZE_WORD = 3'd2
  } cbus_size_e;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    cbus_len_t   len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_BURST = 2'd2,
    S_DONE  = 2'd3
  } resp_state_t;

endpackage

// File: rtl/cbus_mem_array.sv
// Byte-strobed word RAM, one asynchronous read port and one synchronous write port.
// Storage is kept separate so a vendor block RAM can be dropped in.
module cbus_mem_array
  import cbus_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH = 4096,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [3:0]    strobe_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];

  // Contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < CBUS_WORD_BYTES; i++) begin
        if (strobe_i[i]) mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/cbus_mem_responder.sv
// CBus responder backed by a word RAM: single/burst reads and writes after LATENCY cycles.
// Optional CBUS_RESP_STALL_EN inserts LFSR-driven stall cycles into bursts.
module cbus_mem_responder
  import cbus_mem_responder_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 4096,
  parameter int unsigned LATENCY   = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        creq_valid,
  input  logic        creq_is_write,
  input  logic [2:0]  creq_size,
  input  logic [31:0] creq_addr,
  input  logic [3:0]  creq_strobe,
  input  logic [31:0] creq_data,
  input  logic [3:0]  creq_len,
  output logic        cresp_ready,
  output logic        cresp_last,
  output logic [31:0] cresp_data
);

  localparam int unsigned AW = $clog2(MEM_WORDS);

  cbus_req_t   req;
  cbus_resp_t  resp;
  resp_state_t state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [3:0]  beat_q, beat_d, len_q, len_d, wait_q, wait_d;
  logic        is_write_q, is_write_d;
  logic [31:0] offset, rdata;
  logic        stall, beat_fire, mem_we;
  logic        unused_ok;

  assign req = '{valid: creq_valid, is_write: creq_is_write, size: creq_size,
                 addr: creq_addr, strobe: creq_strobe, data: creq_data, len: creq_len};
  assign offset    = req.addr - BASE_ADDR;
  assign unused_ok = ^{req.size, offset[31:AW+2], offset[1:0]};

`ifdef CBUS_RESP_STALL_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr_q <= 16'hACE1;
    else       lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end
  assign stall = lfsr_q[0];
`else
  assign stall = 1'b0;
`endif

  assign beat_fire = (state_q == S_BURST) && !stall;
  // A master that drops valid mid-burst gets no further writes.
  assign mem_we    = beat_fire && is_write_q && req.valid;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    beat_d     = beat_q;
    len_d      = len_q;
    is_write_d = is_write_q;
    wait_d     = wait_q;
    unique case (state_q)
      S_IDLE: begin
        if (req.valid) begin
          addr_d     = offset[AW+1:2];
          len_d      = req.len;
          is_write_d = req.is_write;
          beat_d     = 4'd0;
          wait_d     = 4'(LATENCY - 1);
          state_d    = (LATENCY == 1) ? S_BURST : S_WAIT;
        end
      end
      S_WAIT: begin
        if (!req.valid)          state_d = S_IDLE;
        else if (wait_q == 4'd0) state_d = S_BURST;
        else                     wait_d  = wait_q - 4'd1;
      end
      S_BURST: begin
        if (!req.valid) begin
          state_d = S_IDLE;
        end else if (beat_fire) begin
          addr_d = addr_q + 1'b1;
          beat_d = beat_q + 4'd1;
          if (beat_q == len_q) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      beat_q     <= 4'd0;
      len_q      <= 4'd0;
      is_write_q <= 1'b0;
      wait_q     <= 4'd0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      beat_q     <= beat_d;
      len_q      <= len_d;
      is_write_q <= is_write_d;
      wait_q     <= wait_d;
    end
  end

  cbus_mem_array #(.DEPTH(MEM_WORDS), .AW(AW)) u_mem (
    .clk_i    (clk),
    .we_i     (mem_we),
    .waddr_i  (addr_q),
    .strobe_i (req.strobe),
    .wdata_i  (req.data),
    .raddr_i  (addr_q),
    .rdata_o  (rdata)
  );

  assign resp.ready = beat_fire;
  assign resp.last  = beat_fire && (beat_q == len_q);
  assign resp.data  = (beat_fire && !is_write_q) ? rdata : 32'h0;

  assign cresp_ready = resp.ready;
  assign cresp_last  = resp.last;
  assign cresp_data  = resp.data;

endmodule

// File: tb/tb_cbus_mem_responder.sv
// Directed bench for cbus_mem_responder (MEM_WORDS=4096, LATENCY=2); stall model active under CBUS_RESP_STALL_EN.
module tb_cbus_mem_responder;

`ifdef CBUS_RESP_STALL_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic        clk, reset;
  logic        creq_valid, creq_is_write;
  logic [2:0]  creq_size;
  logic [31:0] creq_addr, creq_data;
  logic [3:0]  creq_strobe, creq_len;
  logic        cresp_ready, cresp_last;
  logic [31:0] cresp_data;

  int errors = 0;
  int checks = 0;
  logic [31:0] wbuf [16];
  logic [31:0] rexp [16];
  logic [15:0] lfsr_m;

  cbus_mem_responder #(.MEM_WORDS(4096), .LATENCY(2), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .reset(reset), .creq_valid(creq_valid), .creq_is_write(creq_is_write),
    .creq_size(creq_size), .creq_addr(creq_addr), .creq_strobe(creq_strobe),
    .creq_data(creq_data), .creq_len(creq_len), .cresp_ready(cresp_ready),
    .cresp_last(cresp_last), .cresp_data(cresp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference stall sequence: 16-bit Fibonacci LFSR, taps 16,14,13,11.
  always @(posedge clk or posedge reset) begin
    if (reset) lfsr_m <= 16'hACE1;
    else       lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One transaction; abort_at >= 0 asserts reset while that beat index is on the bus.
  task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [3:0] len,
                         input logic [3:0] strb, input int abort_at);
    int  b;
    bit  done;
    logic exp_rdy;
    @(posedge clk); #1;
    creq_valid = 1'b1; creq_is_write = wr; creq_addr = addr; creq_len = len;
    creq_strobe = strb; creq_size = 3'd2; creq_data = wbuf[0];
    @(negedge clk);
    chk("accept_rdy", {31'b0, cresp_ready}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("wait_rdy", {31'b0, cresp_ready}, 32'd0);
      chk("wait_data", cresp_data, 32'd0);
    end
    b = 0;
    done = 1'b0;
    for (int cyc = 0; cyc < 80 && !done; cyc++) begin
      @(posedge clk); #1;
      creq_data = (b < 16) ? wbuf[b] : 32'h0;
      @(negedge clk);
      exp_rdy = STALL_EN ? !lfsr_m[0] : 1'b1;
      chk("beat_rdy", {31'b0, cresp_ready}, {31'b0, exp_rdy});
      if (cresp_ready) begin
        if (b == abort_at) begin
          reset = 1'b1;
          #1;
          chk("abort_rdy", {31'b0, cresp_ready}, 32'd0);
          chk("abort_last", {31'b0, cresp_last}, 32'd0);
          chk("abort_data", cresp_data, 32'd0);
          creq_valid = 1'b0;
          @(posedge clk); #1;
          reset = 1'b0;
          return;
        end
        chk("beat_last", {31'b0, cresp_last}, {31'b0, (b == int'(len))});
        chk("beat_data", cresp_data, wr ? 32'h0 : rexp[b]);
        if (b == int'(len)) done = 1'b1;
        b++;
      end
    end
    chk("burst_done", {31'b0, done}, 32'd1);
    @(posedge clk); #1;
    creq_valid = 1'b0;
    @(negedge clk);
    chk("done_rdy", {31'b0, cresp_ready}, 32'd0);
    chk("done_last", {31'b0, cresp_last}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; creq_valid = 1'b0; creq_is_write = 1'b0; creq_size = 3'd0;
    creq_addr = 32'h0; creq_data = 32'h0; creq_strobe = 4'h0; creq_len = 4'h0;
    #1;
    chk("rst_rdy", {31'b0, cresp_ready}, 32'd0);
    chk("rst_last", {31'b0, cresp_last}, 32'd0);
    chk("rst_data", cresp_data, 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Single write then single read of word 0x10.
    wbuf[0] = 32'hDEADBEEF;
    run_txn(1'b1, 32'h40, 4'd0, 4'hF, -1);
    rexp[0] = 32'hDEADBEEF;
    run_txn(1'b0, 32'h40, 4'd0, 4'hF, -1);

    // 16-beat write and read of words 0x100..0x10F.
    for (int i = 0; i < 16; i++) begin wbuf[i] = 32'h100 + i; rexp[i] = 32'h100 + i; end
    run_txn(1'b1, 32'h400, 4'd15, 4'hF, -1);
    run_txn(1'b0, 32'h400, 4'd15, 4'hF, -1);

    // 8-beat read (exercises stall pattern when enabled).
    run_txn(1'b0, 32'h400, 4'd7, 4'hF, -1);

    // Strobed write merges bytes 0 and 2.
    wbuf[0] = 32'h11223344;
    run_txn(1'b1, 32'h80, 4'd0, 4'hF, -1);
    wbuf[0] = 32'hAABBCCDD;
    run_txn(1'b1, 32'h80, 4'd0, 4'b0101, -1);
    rexp[0] = 32'h11BB33DD;
    run_txn(1'b0, 32'h80, 4'd0, 4'hF, -1);

    // Wrap-around from word 4094; word 2 must be untouched.
    wbuf[0] = 32'hCAFEF00D;
    run_txn(1'b1, 32'h8, 4'd0, 4'hF, -1);
    for (int i = 0; i < 4; i++) begin wbuf[i] = 32'hA0 + i; rexp[i] = 32'hA0 + i; end
    run_txn(1'b1, 32'h3FF8, 4'd3, 4'hF, -1);
    run_txn(1'b0, 32'h3FF8, 4'd3, 4'hF, -1);
    rexp[0] = 32'hCAFEF00D;
    run_txn(1'b0, 32'h8, 4'd0, 4'hF, -1);

    // Reset on the third beat of an 8-beat write: only the first two beats land.
    for (int i = 0; i < 8; i++) wbuf[i] = 32'h5500_0000 + i;
    run_txn(1'b1, 32'h800, 4'd7, 4'hF, -1);
    for (int i = 0; i < 8; i++) wbuf[i] = 32'h7700_0000 + i;
    run_txn(1'b1, 32'h800, 4'd7, 4'hF, 2);
    for (int i = 0; i < 8; i++) rexp[i] = (i < 2) ? 32'h7700_0000 + i : 32'h5500_0000 + i;
    run_txn(1'b0, 32'h800, 4'd7, 4'hF, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
